sc_intc: RTL and testbench
==========================

// Module: sc_intc
// PURPOSE
//  Memory-mapped priority interrupt controller for the single-cycle MIPS core.
//  Collects NSRC peripheral interrupt lines, latches rising edges as pending,
//  applies a mask, and drives the CPU's single intr input. It consumes the CPU's
//  inta acknowledge and exposes the granted source id to the handler. Sits on the
//  data-memory bus beside the data RAM, selected by an address decode.
// PARAMETERS
//  NSRC      8            number of interrupt sources (1..16)
//  BASE_ADDR 32'h0000_0F00 word-aligned base of the 16-byte register window
// PORTS
//  clock   in   1     system clock, rising edge
//  reset   in   1     asynchronous, active-high reset
//  irq     in   NSRC  source lines, synchronous to clock
//  intr    out  1     interrupt request to CPU (registered)
//  inta    in   1     CPU acknowledge, one-cycle pulse
//  addr    in   32    bus address (CPU aluout)
//  wdata   in   32    bus write data
//  we      in   1     bus write enable (CPU wmem)
//  rdata   out  32    read data; 0 when addr is outside the window
//  hit     out  1     addr in [BASE_ADDR, BASE_ADDR+15]; steers CPU read mux
// BEHAVIOUR
//  Reset: intr=0; pend, mask, irq_q, cur_id=0; valid=0; state=IDLE.
//  Register map (offset; bits above NSRC read 0):
//   0x0 PEND  R / W1C : pending bits
//   0x4 MASK  RW      : 1 = source enabled
//   0x8 CAUSE R       : {valid at bit31, 27'b0, cur_id[3:0]}
//   0xC EOI   W       : any write ends service
//  Writes to R-only offsets are ignored. Reads are combinational.
//  Edge capture: if irq[i]=1 and irq_q[i]=0 at edge k, pend[i]=1 after edge k.
//  Eligible set: elig = pend & mask. Lowest index has highest priority.
//  FSM, next state at each edge:
//   IDLE: elig!=0 -> REQ; intr=1 from that edge onward.
//         Latency: irq rise sampled at edge k -> intr=1 after edge k+1.
//   REQ:  inta & elig!=0 -> SERV: cur_id=prio(elig), valid=1,
//           pend[cur_id] cleared, intr=0.
//         inta & elig==0 -> IDLE: spurious ack, valid=0, cur_id=4'hF, intr=0.
//         elig==0 (masked or W1C before ack) -> IDLE, intr=0.
//   SERV: intr=0; nesting is not supported.
//         EOI write -> IDLE, valid=0; a still-eligible source re-raises intr
//           one cycle later through IDLE->REQ.
//  Ignored events: inta outside REQ; EOI outside SERV.
//  Same-cycle collisions on one bit: set wins.
//   - new edge vs W1C clear: pend stays 1.
//   - new edge vs inta clear: pend stays 1, so the source re-requests after EOI.
//  MASK write and inta in the same cycle: elig uses the old mask.
//  Asynchronous reset in any state returns every register to its reset value
//   immediately. intr drops with no handshake.
// STRUCTURE
//  Include file sc_intc_defs.v holds:
//   - offsets OFF_PEND, OFF_MASK, OFF_CAUSE, OFF_EOI
//   - state codes S_IDLE=2'd0, S_REQ=2'd1, S_SERV=2'd2
//   - SPURIOUS_ID=4'hF
//  One sub-module, sc_intc_prio: combinational NSRC-bit priority encoder
//   -> {any, id[3:0]}.
//  Top level holds edge detect, pend/mask regs, FSM, bus decode and read mux.
// TESTING
//  1 MASK=0x01, pulse irq[0] at edge 10 -> pend=0x01 after 10, intr=1 after 11;
//    inta -> CAUSE=0x8000_0000, pend=0, intr=0; EOI -> CAUSE=0.
//  2 MASK=0xFF, irq[5] and irq[2] rise together -> ack gives id 2, pend=0x20;
//    EOI -> intr=1 two cycles later; ack gives id 5.
//  3 irq[3] rises with MASK=0 -> pend=0x08, intr stays 0;
//    write MASK=0x08 -> intr=1 two edges later.
//  4 In REQ, W1C PEND=0x08 -> intr=0 next cycle, state IDLE;
//    inta then -> no state change.
//  5 W1C PEND bit 1 in the same cycle as an irq[1] rising edge -> pend[1]=1.
//    inta in REQ with elig cleared that cycle -> CAUSE=0x0000_000F.
//  6 Assert reset while in SERV -> intr=0, CAUSE=0, MASK=0 immediately;
//    irq edges during reset are not latched.

Source files
------------

// File: rtl/sc_intc_pkg.sv
// Shared definitions for the sc_intc interrupt controller:
// register offsets, FSM state codes and the spurious-ack id.
package sc_intc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    localparam logic [3:0] OFF_PEND  = 4'h0;
    localparam logic [3:0] OFF_MASK  = 4'h4;
    localparam logic [3:0] OFF_CAUSE = 4'h8;
    localparam logic [3:0] OFF_EOI   = 4'hC;

    localparam logic [3:0] SPURIOUS_ID = 4'hF;

    // CAUSE register image: valid flag on top, source id in the low nibble.
    function automatic logic [31:0] cause_word(logic v, logic [3:0] id);
        return {v, 27'b0, id};
    endfunction

endpackage

// File: rtl/sc_intc_if.sv
// Data-memory bus slice seen by the interrupt controller.
// The CPU side is master; the controller is slave.
interface sc_intc_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata,
        input  hit
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata,
        output hit
    );

endinterface

// File: rtl/sc_intc_prio.sv
// Combinational priority encoder: lowest set index wins.
// Reports whether any request is present and its 4-bit id.
module sc_intc_prio #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [3:0]      id
);

    // Scan downward so the lowest set bit is the last assignment.
    always_comb begin
        any = |req;
        id  = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = i[3:0];
            end
        end
    end

endmodule

// File: rtl/sc_intc.sv
// Memory-mapped priority interrupt controller for the single-cycle core:
// edge capture, pending/mask registers, request FSM and bus window.
module sc_intc
    import sc_intc_pkg::*;
#(
    parameter int          NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    output logic            intr,
    input  logic            inta,
    sc_intc_if.slave        bus
);

    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] ack_clr;
    logic [3:0]      cur_id;
    logic            valid;
    logic [3:0]      prio_id;
    logic            prio_any;
    state_t          state;
    state_t          state_n;
    logic            ack;
    logic            spur;
    logic            eoi;
    logic [31:0]     rel;
    logic [3:0]      reg_off;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_eoi;
    logic            unused_bits;

    // Window decode relative to the base; low two address bits ignored.
    assign rel     = bus.addr - BASE_ADDR;
    assign bus.hit = (bus.addr >= BASE_ADDR) && (rel < 32'd16);
    assign reg_off = {rel[3:2], 2'b00};

    assign wr_pend = bus.we && bus.hit && (reg_off == OFF_PEND);
    assign wr_mask = bus.we && bus.hit && (reg_off == OFF_MASK);
    assign wr_eoi  = bus.we && bus.hit && (reg_off == OFF_EOI);

    assign elig = pend & mask;
    assign rise = irq & ~irq_q;
    assign w1c  = wr_pend ? bus.wdata[NSRC-1:0] : '0;

    assign unused_bits = ^{bus.wdata, rel[1:0]};

    sc_intc_prio #(
        .NSRC(NSRC)
    ) u_prio (
        .req(elig),
        .any(prio_any),
        .id (prio_id)
    );

    // One-hot clear of the source being granted.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack && (prio_id == i[3:0]);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // FSM next state plus grant / spurious / end-of-service strobes.
    always_comb begin
        state_n = state;
        ack     = 1'b0;
        spur    = 1'b0;
        eoi     = 1'b0;
        case (state)
            S_IDLE: begin
                if (prio_any) state_n = S_REQ;
            end
            S_REQ: begin
                if (inta && prio_any) begin
                    state_n = S_SERV;
                    ack     = 1'b1;
                end else if (inta) begin
                    state_n = S_IDLE;
                    spur    = 1'b1;
                end else if (!prio_any) begin
                    state_n = S_IDLE;
                end
            end
            S_SERV: begin
                if (wr_eoi) begin
                    state_n = S_IDLE;
                    eoi     = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered request line: high exactly while waiting for an ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) intr <= 1'b0;
        else       intr <= (state_n == S_REQ);
    end

    // Edge history for rising-edge capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) irq_q <= '0;
        else       irq_q <= irq;
    end

    // Pending bits: a new edge beats any same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pend <= '0;
        else       pend <= (pend & ~w1c & ~ack_clr) | rise;
    end

    // Mask register; a same-cycle ack still sees the old mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        mask <= '0;
        else if (wr_mask) mask <= bus.wdata[NSRC-1:0];
    end

    // Granted id and valid flag shown through CAUSE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_id <= 4'd0;
            valid  <= 1'b0;
        end else if (ack) begin
            cur_id <= prio_id;
            valid  <= 1'b1;
        end else if (spur) begin
            cur_id <= SPURIOUS_ID;
            valid  <= 1'b0;
        end else if (eoi) begin
            valid  <= 1'b0;
        end
    end

    // Combinational read mux; zero outside the window and for EOI.
    always_comb begin
        bus.rdata = '0;
        if (bus.hit) begin
            case (reg_off)
                OFF_PEND:  bus.rdata = 32'(pend);
                OFF_MASK:  bus.rdata = 32'(mask);
                OFF_CAUSE: bus.rdata = cause_word(valid, cur_id);
                default:   bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_intc.sv
// Randomized self-checking bench for sc_intc against a
// cycle-level behavioural model of the controller.
module tb_sc_intc;

    localparam int          NSRC = 8;
    localparam logic [31:0] B    = 32'h0000_0F00;
    localparam logic [31:0] NM   = 32'h0000_00FF;

    logic            clock;
    logic            reset;
    logic [NSRC-1:0] irq;
    logic            intr;
    logic            inta;

    sc_intc_if bus ();

    sc_intc #(
        .NSRC     (NSRC),
        .BASE_ADDR(B)
    ) dut (
        .clock(clock),
        .reset(reset),
        .irq  (irq),
        .intr (intr),
        .inta (inta),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus applied for the coming edge
    logic [7:0]  s_irq;
    logic        s_inta;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    // model: controller seen as "waiting for ack" / "in service"
    logic [31:0] m_pend;
    logic [31:0] m_mask;
    logic [31:0] m_prev;
    logic        m_wait_ack;
    logic        m_in_service;
    logic        m_valid;
    logic [3:0]  m_id;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(logic [31:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend       = 0;
        m_mask       = 0;
        m_prev       = 0;
        m_wait_ack   = 0;
        m_in_service = 0;
        m_valid      = 0;
        m_id         = 0;
    endtask

    // Advance the model by one clock edge using the stimulus in s_*.
    task automatic model_step();
        logic [31:0] elig;
        logic [31:0] nxt;
        logic [31:0] irqv;
        logic        inwin;
        int          word;
        int          g;
        elig  = m_pend & m_mask;
        irqv  = {24'b0, s_irq};
        inwin = (s_addr >= B) && (s_addr <= B + 32'd15);
        word  = int'((s_addr - B) >> 2) & 3;
        nxt   = m_pend;
        if (m_wait_ack) begin
            if (s_inta && elig != 0) begin
                g            = lowest(elig);
                m_id         = 4'(g);
                m_valid      = 1;
                nxt          = nxt & ~(32'd1 << g);
                m_wait_ack   = 0;
                m_in_service = 1;
            end else if (s_inta) begin
                m_id       = 4'hF;
                m_valid    = 0;
                m_wait_ack = 0;
            end else if (elig == 0) begin
                m_wait_ack = 0;
            end
        end else if (m_in_service) begin
            if (s_we && inwin && word == 3) begin
                m_in_service = 0;
                m_valid      = 0;
            end
        end else if (elig != 0) begin
            m_wait_ack = 1;
        end
        if (s_we && inwin && word == 0) nxt = nxt & ~s_wdata;
        nxt    = (nxt | (irqv & ~m_prev)) & NM;
        m_pend = nxt;
        if (s_we && inwin && word == 1) m_mask = s_wdata & NM;
        m_prev = irqv;
    endtask

    task automatic restore_bus();
        bus.addr  = s_addr;
        bus.we    = s_we;
        bus.wdata = s_wdata;
    endtask

    // One edge: update model, then compare intr and the three readable registers.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1 check("intr", 32'(intr), 32'(m_intr_exp()));
        bus.we   = 1'b0;
        bus.addr = B;
        #1 check("pend", bus.rdata, m_pend);
        bus.addr = B + 32'd4;
        #1 check("mask", bus.rdata, m_mask);
        bus.addr = B + 32'd8;
        #1 check("cause", bus.rdata, {m_valid, 27'b0, m_id});
        restore_bus();
    endtask

    function automatic logic m_intr_exp();
        return m_wait_ack;
    endfunction

    task automatic cyc(logic [7:0] i, logic a, logic w, logic [31:0] ad, logic [31:0] d);
        s_irq   = i;
        s_inta  = a;
        s_we    = w;
        s_addr  = ad;
        s_wdata = d;
        irq     = i;
        inta    = a;
        restore_bus();
        tick();
    endtask

    task automatic idle();
        cyc(s_irq, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Single combinational read at an arbitrary address.
    task automatic probe(string tag, logic [31:0] ad, logic eh, logic [31:0] ed);
        bus.we   = 1'b0;
        bus.addr = ad;
        #1;
        check({tag, "_hit"}, 32'(bus.hit), 32'(eh));
        check({tag, "_rd"}, bus.rdata, ed);
        restore_bus();
    endtask

    initial begin
        reset   = 1'b1;
        s_irq   = '0;
        s_inta  = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        irq     = '0;
        inta    = 1'b0;
        restore_bus();
        model_reset();

        // reset values
        #1;
        check("rst_intr", 32'(intr), 32'd0);
        probe("rst_pend", B, 1'b1, 32'd0);
        probe("rst_cause", B + 32'd8, 1'b1, 32'd0);
        #9 reset = 1'b0;

        // 1: single source, ack and EOI
        cyc(8'h00, 0, 1, B + 32'd4, 32'h01);
        cyc(8'h01, 0, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 0);
        check("t1_intr", 32'(intr), 32'd1);
        cyc(8'h00, 1, 0, 0, 0);
        probe("t1_cause", B + 32'd8, 1'b1, 32'h8000_0000);
        cyc(8'h00, 0, 1, B + 32'd12, 32'h0);
        probe("t1_eoi", B + 32'd8, 1'b1, 32'h0);

        // 2: two sources, lowest wins, second re-requests after EOI
        cyc(8'h00, 0, 1, B + 32'd4, 32'hFF);
        cyc(8'h24, 0, 0, 0, 0);
        idle();
        idle();
        cyc(8'h24, 1, 0, 0, 0);
        probe("t2_cause", B + 32'd8, 1'b1, 32'h8000_0002);
        probe("t2_pend", B, 1'b1, 32'h20);
        cyc(8'h24, 0, 1, B + 32'd12, 32'h0);
        idle();
        idle();
        check("t2_reraise", 32'(intr), 32'd1);
        cyc(8'h00, 1, 0, 0, 0);
        probe("t2_cause5", B + 32'd8, 1'b1, 32'h8000_0005);
        cyc(8'h00, 0, 1, B + 32'd12, 32'h0);

        // 3: masked source pends silently until unmasked
        cyc(8'h00, 0, 1, B + 32'd4, 32'h00);
        cyc(8'h08, 0, 0, 0, 0);
        idle();
        idle();
        probe("t3_pend", B, 1'b1, 32'h08);
        cyc(8'h08, 0, 1, B + 32'd4, 32'h08);
        idle();
        check("t3_intr", 32'(intr), 32'd1);

        // 4: W1C before ack withdraws the request; late inta ignored
        cyc(8'h08, 0, 1, B, 32'h08);
        idle();
        check("t4_intr", 32'(intr), 32'd0);
        cyc(8'h08, 1, 0, 0, 0);
        idle();

        // 5: set beats W1C; spurious ack after clear
        cyc(8'h00, 0, 1, B + 32'd4, 32'h02);
        cyc(8'h02, 0, 1, B, 32'h02);
        probe("t5_pend", B, 1'b1, 32'h02);
        idle();
        cyc(8'h02, 0, 1, B, 32'h02);
        cyc(8'h02, 1, 0, 0, 0);
        probe("t5_spur", B + 32'd8, 1'b1, 32'h0000_000F);

        // window boundaries
        probe("win_lo", B - 32'd1, 1'b0, 32'h0);
        idle();
        probe("win_hi", B + 32'd15, 1'b1, 32'h0);
        idle();
        probe("win_out", B + 32'd16, 1'b0, 32'h0);
        idle();

        // 6: reset while in service
        cyc(8'h00, 0, 0, 0, 0);
        cyc(8'h02, 0, 0, 0, 0);
        idle();
        cyc(8'h02, 1, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("t6_intr", 32'(intr), 32'd0);
        probe("t6_cause", B + 32'd8, 1'b1, 32'h0);
        probe("t6_mask", B + 32'd4, 1'b1, 32'h0);
        irq = 8'hFF;
        @(posedge clock);
        irq = 8'h00;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        s_irq = '0;
        idle();
        idle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [7:0]  ni;
            logic        na;
            logic        nw;
            logic [31:0] nad;
            logic [31:0] nd;
            ni  = s_irq ^ 8'($urandom & $urandom & $urandom);
            na  = ($urandom_range(0, 2) == 0);
            nw  = ($urandom_range(0, 3) == 0);
            nad = B + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) nad = B + 32'd16;
            nd  = $urandom;
            cyc(ni, na, nw, nad, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
